// File: rtl/dmem_copy_engine.sv
// Block mover on the data-memory port: COPY (read then write per word) or FILL (write constant per word).
// Latency start edge -> done: COPY 2N+1, FILL N+1, zero-length or misaligned 1 cycle.
// No backpressure: memory is single-cycle; start is accepted only in IDLE, never queued.
module dmem_copy_engine #(
    parameter int LEN_WIDTH  = 8,
    parameter int WORD_BYTES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 mode,
    input  logic [31:0]          src_addr,
    input  logic [31:0]          dst_addr,
    input  logic [LEN_WIDTH-1:0] len_words,
    input  logic [31:0]          fill_value,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic [31:0]          Address,
    output logic [31:0]          Write_data,
    input  logic [31:0]          Read_data
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

    state_t               state_q, state_d;
    logic                 armed_q;
    logic                 mode_q, mode_d;
    logic [31:0]          src_q, src_d;
    logic [31:0]          dst_q, dst_d;
    logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
    logic [31:0]          buf_q, buf_d;
    logic [31:0]          fill_q, fill_d;
    logic                 err_d;

    logic                 busy_d, done_d, err_out_d, rd_d, wr_d;
    logic [31:0]          addr_d, wdata_d;

    // Next-state, datapath updates, and the output values for the coming cycle
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        fill_d  = fill_q;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // armed_q masks a start coinciding with the reset-release edge
                if (start && armed_q) begin
                    mode_d = mode;
                    src_d  = src_addr;
                    dst_d  = dst_addr;
                    cnt_d  = len_words;
                    fill_d = fill_value;
                    if ((!mode && src_addr[1:0] != 2'b00) || dst_addr[1:0] != 2'b00) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (len_words == '0) begin
                        state_d = S_DONE;
                    end else if (!mode) begin
                        state_d = S_READ;
                    end else begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_READ: begin
                buf_d   = Read_data;
                src_d   = src_q + 32'(WORD_BYTES);
                state_d = S_WRITE;
            end
            S_WRITE: begin
                dst_d = dst_q + 32'(WORD_BYTES);
                cnt_d = cnt_q - LEN_WIDTH'(1);
                if (cnt_q == LEN_WIDTH'(1)) begin
                    state_d = S_DONE;
                end else if (!mode_q) begin
                    state_d = S_READ;
                end else begin
                    state_d = S_WRITE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they can leave a flop directly
        rd_d      = (state_d == S_READ);
        wr_d      = (state_d == S_WRITE);
        busy_d    = rd_d || wr_d;
        done_d    = (state_d == S_DONE);
        err_out_d = done_d && err_d;
        addr_d    = rd_d ? src_d : (wr_d ? dst_d : 32'h0);
        wdata_d   = wr_d ? (mode_d ? fill_d : buf_d) : 32'h0;
    end

    // State, command registers and registered bus outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            armed_q    <= 1'b0;
            mode_q     <= 1'b0;
            src_q      <= 32'h0;
            dst_q      <= 32'h0;
            cnt_q      <= '0;
            buf_q      <= 32'h0;
            fill_q     <= 32'h0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            MemRead    <= 1'b0;
            MemWrite   <= 1'b0;
            Address    <= 32'h0;
            Write_data <= 32'h0;
        end else begin
            state_q    <= state_d;
            armed_q    <= 1'b1;
            mode_q     <= mode_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            cnt_q      <= cnt_d;
            buf_q      <= buf_d;
            fill_q     <= fill_d;
            busy       <= busy_d;
            done       <= done_d;
            err        <= err_out_d;
            MemRead    <= rd_d;
            MemWrite   <= wr_d;
            Address    <= addr_d;
            Write_data <= wdata_d;
        end
    end

endmodule

// File: tb/tb_dmem_copy_engine.sv
// Bench for dmem_copy_engine: word-addressed memory model, reference memory image, directed plus random ops.
// Each op is checked for latency, err, strobe counts, busy continuity and the full memory image.
// All waits on the DUT are bounded; a missed done shows up as a failed check.
module tb_dmem_copy_engine;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        mode  = 1'b0;
    logic [31:0] src_addr = '0;
    logic [31:0] dst_addr = '0;
    logic [7:0]  len_words = '0;
    logic [31:0] fill_value = '0;
    logic        busy, done, err, MemRead, MemWrite;
    logic [31:0] Address, Write_data, Read_data;

    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];
    logic        bd_we  = 1'b0;
    logic [7:0]  bd_idx = '0;
    logic [31:0] bd_dat = '0;

    int n_rd = 0, n_wr = 0, n_both = 0;
    logic [31:0] last_wa = '0, prev_wa = '0;

    int passed = 0, fails = 0, total = 0;
    int skip_idx = -1;

    dmem_copy_engine #(.LEN_WIDTH(8), .WORD_BYTES(4)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .src_addr(src_addr), .dst_addr(dst_addr), .len_words(len_words),
        .fill_value(fill_value), .busy(busy), .done(done), .err(err),
        .MemRead(MemRead), .MemWrite(MemWrite), .Address(Address),
        .Write_data(Write_data), .Read_data(Read_data)
    );

    always #5 clk = ~clk;

    // Memory decodes only Address[9:2]; combinational read, write on rising edge
    assign Read_data = mem[Address[9:2]];

    always @(posedge clk) begin
        if (bd_we) mem[bd_idx] <= bd_dat;
        else if (MemWrite) mem[Address[9:2]] <= Write_data;
    end

    // Strobe activity counters and recent write addresses
    always @(posedge clk) begin
        if (MemRead) n_rd <= n_rd + 1;
        if (MemWrite) begin
            n_wr    <= n_wr + 1;
            prev_wa <= last_wa;
            last_wa <= Address;
        end
        if (MemRead && MemWrite) n_both <= n_both + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int mem_mismatches();
        int c = 0;
        for (int i = 0; i < 256; i++)
            if (i != skip_idx && mem[i] !== ref_mem[i]) c++;
        return c;
    endfunction

    task automatic drive_random_cmd();
        mode       = 1'($urandom);
        src_addr   = $urandom;
        dst_addr   = $urandom;
        len_words  = 8'($urandom);
        fill_value = $urandom;
    endtask

    // Issue one command and wait (bounded) for done; optional extra start at cycle inj
    task automatic run_op(input logic m, input logic [31:0] s, input logic [31:0] d,
                          input logic [7:0] l, input logic [31:0] f, input int inj,
                          output logic got, output int lat, output logic e,
                          output int nrd, output int nwr, output int gaps);
        int rd0, wr0;
        @(negedge clk);
        start = 1'b1; mode = m; src_addr = s; dst_addr = d; len_words = l; fill_value = f;
        rd0 = n_rd; wr0 = n_wr;
        @(posedge clk);
        #1;
        start = 1'b0;
        drive_random_cmd();
        got = 1'b0; lat = 0; e = 1'b0; gaps = 0;
        for (int k = 1; k <= 600 && !got; k++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1; lat = k; e = err;
            end else if (!busy) begin
                gaps++;
            end
            if (k == inj) begin
                drive_random_cmd();
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        nrd = n_rd - rd0;
        nwr = n_wr - wr0;
    endtask

    // Reference: apply the command to ref_mem word by word in ascending order
    task automatic do_op(input string tag, input logic m, input logic [31:0] s,
                         input logic [31:0] d, input logic [7:0] l, input logic [31:0] f,
                         input int inj);
        logic exp_err, noop, got, e;
        int exp_lat, exp_rd, exp_wr, lat, nrd, nwr, gaps;
        logic [31:0] sa, da;
        exp_err = (!m && s[1:0] != 2'b00) || d[1:0] != 2'b00;
        noop    = exp_err || l == 8'd0;
        exp_lat = noop ? 1 : (m ? int'(l) + 1 : 2 * int'(l) + 1);
        exp_rd  = (noop || m) ? 0 : int'(l);
        exp_wr  = noop ? 0 : int'(l);
        if (!noop) begin
            for (int i = 0; i < int'(l); i++) begin
                sa = s + 32'(4 * i);
                da = d + 32'(4 * i);
                ref_mem[da[9:2]] = m ? f : ref_mem[sa[9:2]];
            end
        end
        run_op(m, s, d, l, f, inj, got, lat, e, nrd, nwr, gaps);
        check({tag, "_done_seen"}, 64'(got), 64'(1));
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_err"}, 64'(e), 64'(exp_err));
        check({tag, "_reads"}, 64'(nrd), 64'(exp_rd));
        check({tag, "_writes"}, 64'(nwr), 64'(exp_wr));
        check({tag, "_busy_gaps"}, 64'(gaps), 64'(0));
        check({tag, "_mem_image"}, 64'(mem_mismatches()), 64'(0));
    endtask

    logic [31:0] sp_img [0:5];
    logic [31:0] w4, r, r2, vfill;
    int          wr_snap;
    logic        rm;
    logic [31:0] rs, rd;
    logic [7:0]  rl;

    initial begin
        sp_img[0] = 32'd0;  sp_img[1] = 32'd9;  sp_img[2] = 32'd3;
        sp_img[3] = 32'd6;  sp_img[4] = 32'hFFFF_FFFF; sp_img[5] = 32'hFFFF_FFFF;

        // Reset state
        #2 reset = 1'b0;
        #1;
        check("reset_ctrl", 64'({busy, done, err, MemRead, MemWrite}), 64'(0));
        check("reset_addr", 64'(Address), 64'(0));
        check("reset_wdata", 64'(Write_data), 64'(0));

        // Preload memory: random image with the shortest-path row at words 1..6
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            r = (i >= 1 && i <= 6) ? sp_img[i-1] : $urandom;
            bd_we = 1'b1; bd_idx = 8'(i); bd_dat = r; ref_mem[i] = r;
        end
        @(negedge clk) bd_we = 1'b0;
        @(negedge clk) reset = 1'b1;
        repeat (2) @(negedge clk);

        // Directed operations
        do_op("copy_row", 1'b0, 32'h04, 32'h300, 8'd6, 32'h0, 0);
        for (int i = 0; i < 6; i++) check("copy_row_word", 64'(mem[192+i]), 64'(sp_img[i]));
        do_op("fill_neg1", 1'b1, 32'h0, 32'h84, 8'd6, 32'hFFFF_FFFF, 0);
        do_op("copy_len0", 1'b0, 32'h40, 32'h80, 8'd0, 32'h0, 0);
        do_op("copy_misal", 1'b0, 32'h06, 32'h200, 8'd3, 32'h0, 0);

        // Start during busy is ignored
        do_op("copy_inject", 1'b0, 32'h100, 32'h180, 8'd4, 32'h0, 3);
        wr_snap = n_wr;
        repeat (4) @(negedge clk);
        check("inject_idle_busy", 64'(busy), 64'(0));
        check("inject_no_writes", 64'(n_wr - wr_snap), 64'(0));

        // Overlapping copy propagates word 4 forward
        w4 = ref_mem[4];
        do_op("copy_overlap", 1'b0, 32'h10, 32'h14, 8'd3, 32'h0, 0);
        for (int i = 5; i <= 7; i++) check("overlap_word", 64'(mem[i]), 64'(w4));

        // Address wrap past 0xFFFFFFFC
        do_op("fill_wrap", 1'b1, 32'h0, 32'hFFFF_FFFC, 8'd2, 32'hA5A5_0001, 0);
        check("wrap_first_addr", 64'(prev_wa), 64'(32'hFFFF_FFFC));
        check("wrap_second_addr", 64'(last_wa), 64'(32'h0));

        // Reset during the third write of a 6-word FILL at 0x240 (words 144..149)
        vfill = 32'h1234_5678;
        @(negedge clk);
        start = 1'b1; mode = 1'b1; src_addr = 32'h0; dst_addr = 32'h240;
        len_words = 8'd6; fill_value = vfill;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mid_wr_phase", 64'({MemWrite, Address}), 64'({1'b1, 32'h248}));
        reset = 1'b0;
        wr_snap = n_wr;
        #1;
        check("rst_mid_ctrl", 64'({busy, done, err, MemRead, MemWrite}), 64'(0));
        check("rst_mid_addr", 64'(Address), 64'(0));
        check("rst_mid_wdata", 64'(Write_data), 64'(0));
        ref_mem[144] = vfill; ref_mem[145] = vfill;
        skip_idx = 146;
        repeat (3) @(negedge clk);
        check("rst_mid_no_writes", 64'(n_wr - wr_snap), 64'(0));
        check("rst_mid_mem_image", 64'(mem_mismatches()), 64'(0));

        // Start coinciding with the reset-release edge is ignored
        @(negedge clk);
        start = 1'b1; mode = 1'b1; dst_addr = 32'h40; len_words = 8'd2; fill_value = 32'hDEAD_BEEF;
        wr_snap = n_wr;
        @(posedge clk) reset = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (4) @(negedge clk);
        check("release_start_busy", 64'(busy), 64'(0));
        check("release_start_writes", 64'(n_wr - wr_snap), 64'(0));
        do_op("after_reset_fill", 1'b1, 32'h0, 32'h60, 8'd3, 32'h0BAD_F00D, 0);

        // Random commands in words 0..139
        for (int t = 0; t < 12; t++) begin
            r  = $urandom;
            r2 = $urandom;
            rm = r2[0];
            rl = 8'($urandom_range(1, 12));
            rs = {r[31:10], 8'($urandom_range(0, 127)), 2'b00};
            rd = {r2[31:10], 8'($urandom_range(0, 127)), 2'b00};
            if (r2[3:1] == 3'd0) rs[1:0] = 2'($urandom_range(1, 3));
            if (r2[3:1] == 3'd1) rd[1:0] = 2'($urandom_range(1, 3));
            do_op("rand_op", rm, rs, rd, rl, $urandom, 0);
        end

        check("never_rd_and_wr", 64'(n_both), 64'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dmem_copy_engine.md
Name: dmem_copy_engine

Overview:
- Bus initiator that drives the data-memory load/store interface (MemRead, MemWrite, Address, Write_data, Read_data) to move blocks of 32-bit words without CPU involvement.
- Sits beside the CPU's memory port behind a simple start/done command interface. Typical uses: copying a distance-matrix row to a scratch area, or clearing or filling a region before a run.
- Two modes: COPY (read then write, per word) and FILL (write a constant, per word).

Parameters:
- LEN_WIDTH, 8, width of the word-count field; maximum transfer is 2^LEN_WIDTH-1 words.
- WORD_BYTES, 4, byte stride between consecutive words; addresses are byte addresses.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  command strobe; sampled only in IDLE.
- mode  input  1  0 = COPY, 1 = FILL; latched with start.
- src_addr  input  32  COPY source byte address; latched with start.
- dst_addr  input  32  destination byte address; latched with start.
- len_words  input  LEN_WIDTH  number of words to transfer; latched with start.
- fill_value  input  32  FILL data; latched with start.
- busy  output  1  high while a transfer is in progress.
- done  output  1  one-cycle completion pulse.
- err  output  1  valid with done; misaligned command.
- MemRead  output  1  memory read enable.
- MemWrite  output  1  memory write enable; memory writes on the rising clk edge.
- Address  output  32  byte address to memory.
- Write_data  output  32  store data.
- Read_data  input  32  combinational load data from memory.

Behaviour:
- Reset (reset=0, async): all outputs are 0; state is IDLE; internal address, count and data registers are 0.
- An in-flight transfer is abandoned on reset. Memory keeps the words already written; no further access is issued.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - All memory outputs are 0; busy=0.
  - On an edge with start=1, latch the command, then:
    - if src_addr[1:0]!=0 (COPY only) or dst_addr[1:0]!=0 -> DONE with err=1;
    - else if len_words==0 -> DONE with err=0;
    - else if mode=0 -> READ;
    - else -> WRITE.
- READ (COPY only):
  - busy=1, MemRead=1, Address=current src.
  - At the edge, capture Read_data into the data buffer, advance src by WORD_BYTES, go to WRITE.
- WRITE:
  - busy=1, MemWrite=1, Address=current dst.
  - Write_data = buffer (COPY) or latched fill_value (FILL).
  - At the edge, advance dst by WORD_BYTES and decrement count.
  - If count was 1 -> DONE; else -> READ (COPY) or stay in WRITE (FILL).
- DONE:
  - busy=0, done=1 for exactly one cycle; err is valid only in this cycle, otherwise 0.
  - Memory outputs are 0. Next state is IDLE.
- MemRead and MemWrite are never high in the same cycle. Memory outputs are driven from registers and are glitch-free.
- Latency from the start-sampling edge to the done cycle:
  - COPY: 2N+1 cycles.
  - FILL: N+1 cycles.
  - len=0 or error: 1 cycle.
- Address arithmetic is 32-bit modulo 2^32; wrap-around past 0xFFFFFFFC continues at 0x00000000 with no error.
- The memory decodes only Address[9:2]. Aliasing is the caller's concern.
- Overlapping regions are copied in ascending order, one word at a time. If dst>src and the regions overlap, already-copied words propagate forward; this is defined behaviour.
- start while busy or in DONE is ignored and is not queued. Command inputs are don't-care outside the start-sampling cycle.
- A start asserted in the same cycle as the reset release edge is ignored.

Test Plan:
- Memory preloaded with the shortest-path image. COPY src=0x04, dst=0x300, len=6 -> words 192..197 = 0,9,3,6,-1,-1.
  - done pulses 13 cycles after the start edge.
  - MemRead/MemWrite alternate, each high 6 cycles; err=0.
- FILL dst=0x84, len=6, value=0xFFFFFFFF -> words 33..38 = -1; done after 7 cycles; MemRead never high.
- COPY len=0 -> done one cycle later, err=0, no memory strobes. Misaligned src=0x06 -> done one cycle later with err=1, memory unchanged.
- Assert start with new operands during a 4-word COPY -> ignored; only the original 4 words are written; busy stays continuous.
- Drive reset low during the WRITE of word 3 of a 6-word FILL:
  - all outputs are 0 immediately, with no further writes;
  - words 0-1 of the region are filled and words 3-5 are untouched;
  - the word being written at assertion (word 2) is not checked;
  - a new start after reset release executes normally.
- COPY src=0x10, dst=0x14, len=3 (overlap) -> words 5,6,7 all equal the original word 4. dst=0xFFFFFFFC FILL len=2 -> the second write goes to Address 0x00000000.
